// File: rtl/pipepc_ras.sv
// pipepc_ras: fetch-stage program counter with stall, priority redirect and
// a small circular return-address stack (RAS) for predecoded calls/returns.
//
// Build option: define PIPEPC_RAS_EN to build the return-address stack.
// Without it, calls are plain jumps, returns fetch sequentially, and the
// RAS count and sticky flags read as 0.
module pipepc_ras #(
  parameter int PC_W      = 8,
  parameter int INC       = 1,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wpcir,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_pc,
  input  logic                         is_call,
  input  logic [PC_W-1:0]              call_target,
  input  logic                         is_ret,
  input  logic                         clr_flags,
  output logic [PC_W-1:0]              o_pc,
  output logic [PC_W-1:0]              pc_plus,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;

  assign o_pc    = r_pc;
  assign pc_plus = r_pc + PC_W'(INC);

  // Fetch PC register; the next value is fully resolved combinationally.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its sources, independent of block order.
    if (!rst) r_pc <= PC_W'(RESET_PC);
    else      r_pc <= w_next_pc;
  end

`ifdef PIPEPC_RAS_EN

  logic [PC_W-1:0]  r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_replace;
  logic             w_set_ovf;
  logic             w_set_unf;
  logic [PTR_W-1:0] w_push_idx;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(RAS_DEPTH));
  assign w_push_idx = r_top + PTR_W'(1);

  // Next-PC priority: redirect, stall, call+ret, ret, call, sequential.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    w_next_pc = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_replace = 1'b0;
    w_set_unf = 1'b0;
    if (redirect_valid) begin
      w_next_pc = redirect_pc;
    end else if (wpcir) begin
      if (is_call && is_ret) begin
        w_next_pc = call_target;
        if (w_empty) w_push    = 1'b1;
        else         w_replace = 1'b1;
      end else if (is_ret) begin
        if (w_empty) begin
          w_next_pc = pc_plus;
          w_set_unf = 1'b1;
        end else begin
          w_next_pc = r_ras[r_top];
          w_pop     = 1'b1;
        end
      end else if (is_call) begin
        w_next_pc = call_target;
        w_push    = 1'b1;
      end else begin
        w_next_pc = pc_plus;
      end
    end
    w_set_ovf = w_push & w_full;
  end

  // Stack pointer, occupancy and sticky flags; a full push wraps over the oldest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_top <= w_push_idx;
        if (!w_full) r_count <= r_count + CNT_W'(1);
      end else if (w_pop) begin
        r_top   <= r_top - PTR_W'(1);
        r_count <= r_count - CNT_W'(1);
      end
      r_ovf <= w_set_ovf | (r_ovf & ~clr_flags);
      r_unf <= w_set_unf | (r_unf & ~clr_flags);
    end
  end

  // Return-address storage: push writes above top, call+ret rewrites top.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; an entry is only read once ras_count says
    // it was written, so clearing it would only cost reset fan-out.
    if (w_push)         r_ras[w_push_idx] <= pc_plus;
    else if (w_replace) r_ras[r_top]      <= pc_plus;
  end

  assign ras_count     = r_count;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

`else

  logic w_unused_inputs;

  // Next-PC without a stack: calls jump, returns fall through.
  always_comb begin
    w_next_pc = r_pc;
    if (redirect_valid)  w_next_pc = redirect_pc;
    else if (wpcir) begin
      if (is_call) w_next_pc = call_target;
      else         w_next_pc = pc_plus;
    end
  end

  // Returns and flag clears have no effect in this build.
  assign w_unused_inputs = is_ret ^ clr_flags;

  assign ras_count     = '0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;

`endif

endmodule

// File: tb/tb_pipepc_ras.sv
// tb_pipepc_ras: directed, table-driven bench for pipepc_ras (default
// parameters). Expectations follow PIPEPC_RAS_EN when it is defined.
module tb_pipepc_ras;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wpcir = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic       is_call = 1'b0;
  logic [7:0] call_target = '0;
  logic       is_ret = 1'b0;
  logic       clr_flags = 1'b0;
  logic [7:0] o_pc;
  logic [7:0] pc_plus;
  logic [2:0] ras_count;
  logic       ras_overflow;
  logic       ras_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic       wpcir;
    logic       rv;
    logic [7:0] rpc;
    logic       call;
    logic [7:0] tgt;
    logic       ret;
    logic       clr;
    logic [7:0] e_pc;
    logic [2:0] e_cnt;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vecs[$];

  pipepc_ras dut (
    .clk           (clk),
    .rst           (rst),
    .wpcir         (wpcir),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .is_call       (is_call),
    .call_target   (call_target),
    .is_ret        (is_ret),
    .clr_flags     (clr_flags),
    .o_pc          (o_pc),
    .pc_plus       (pc_plus),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected values with the stack built (pc_en, cnt, ovf, unf) and without (pc_dis).
  task automatic add(input string name, input logic w, input logic rv, input logic [7:0] rpc,
                     input logic call, input logic [7:0] tgt, input logic ret, input logic clr,
                     input logic [7:0] pc_en, input logic [2:0] cnt, input logic ovf,
                     input logic unf, input logic [7:0] pc_dis);
    vec_t v;
    v.name = name; v.wpcir = w; v.rv = rv; v.rpc = rpc; v.call = call; v.tgt = tgt;
    v.ret = ret; v.clr = clr;
`ifdef PIPEPC_RAS_EN
    v.e_pc = pc_en; v.e_cnt = cnt; v.e_ovf = ovf; v.e_unf = unf;
`else
    v.e_pc = pc_dis; v.e_cnt = 3'd0; v.e_ovf = 1'b0; v.e_unf = 1'b0;
`endif
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    wpcir = v.wpcir; redirect_valid = v.rv; redirect_pc = v.rpc;
    is_call = v.call; call_target = v.tgt; is_ret = v.ret; clr_flags = v.clr;
    @(posedge clk);
    #1;
    check({v.name, ".pc"},  {24'd0, o_pc},      {24'd0, v.e_pc});
    check({v.name, ".cnt"}, {29'd0, ras_count}, {29'd0, v.e_cnt});
    check({v.name, ".ovf"}, {31'd0, ras_overflow},  {31'd0, v.e_ovf});
    check({v.name, ".unf"}, {31'd0, ras_underflow}, {31'd0, v.e_unf});
  endtask

  initial begin
    //  name       w  rv rpc    call tgt   ret clr  pc_en cnt ovf unf pc_dis
    add("redir10", 1, 1, 8'h10, 0, 8'h00, 0, 0, 8'h10, 0, 0, 0, 8'h10);
    add("stall1",  0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h10, 0, 0, 0, 8'h10);
    add("stall2",  0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h10, 0, 0, 0, 8'h10);
    add("stall3",  0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h10, 0, 0, 0, 8'h10);
    add("flush",   0, 1, 8'h40, 0, 8'h00, 0, 0, 8'h40, 0, 0, 0, 8'h40);
    add("redir05", 1, 1, 8'h05, 0, 8'h00, 0, 0, 8'h05, 0, 0, 0, 8'h05);
    add("call20",  1, 0, 8'h00, 1, 8'h20, 0, 0, 8'h20, 1, 0, 0, 8'h20);
    add("seq21",   1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h21, 1, 0, 0, 8'h21);
    add("seq22",   1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h22, 1, 0, 0, 8'h22);
    add("ret06",   1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h06, 0, 0, 0, 8'h23);
    add("redir01", 1, 1, 8'h01, 0, 8'h00, 0, 0, 8'h01, 0, 0, 0, 8'h01);
    add("call_a",  1, 0, 8'h00, 1, 8'h10, 0, 0, 8'h10, 1, 0, 0, 8'h10);
    add("seq_a",   1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h11, 1, 0, 0, 8'h11);
    add("call_b",  1, 0, 8'h00, 1, 8'h20, 0, 0, 8'h20, 2, 0, 0, 8'h20);
    add("seq_b",   1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h21, 2, 0, 0, 8'h21);
    add("call_c",  1, 0, 8'h00, 1, 8'h30, 0, 0, 8'h30, 3, 0, 0, 8'h30);
    add("seq_c",   1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h31, 3, 0, 0, 8'h31);
    add("call_d",  1, 0, 8'h00, 1, 8'h40, 0, 0, 8'h40, 4, 0, 0, 8'h40);
    add("seq_d",   1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h41, 4, 0, 0, 8'h41);
    add("call_ovf",1, 0, 8'h00, 1, 8'h50, 0, 0, 8'h50, 4, 1, 0, 8'h50);
    add("ret42",   1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h42, 3, 1, 0, 8'h51);
    add("ret32",   1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h32, 2, 1, 0, 8'h52);
    add("ret22",   1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h22, 1, 1, 0, 8'h53);
    add("ret12",   1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h12, 0, 1, 0, 8'h54);
    add("ret_unf", 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h13, 0, 1, 1, 8'h55);
    add("redir05b",1, 1, 8'h05, 0, 8'h00, 0, 0, 8'h05, 0, 1, 1, 8'h05);
    add("call30",  1, 0, 8'h00, 1, 8'h30, 0, 0, 8'h30, 1, 1, 1, 8'h30);
    add("callret", 1, 0, 8'h00, 1, 8'h60, 1, 0, 8'h60, 1, 1, 1, 8'h60);
    add("ret31",   1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h31, 0, 1, 1, 8'h61);
    add("unf_clr", 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'h32, 0, 0, 1, 8'h62);
    add("clr",     1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h33, 0, 0, 0, 8'h63);
    add("cr_empty",1, 0, 8'h00, 1, 8'h70, 1, 0, 8'h70, 1, 0, 0, 8'h70);
    add("ret34",   1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h34, 0, 0, 0, 8'h71);
    add("redir_pr",1, 1, 8'h80, 1, 8'h99, 1, 0, 8'h80, 0, 0, 0, 8'h80);
    add("stall_cl",0, 0, 8'h00, 1, 8'h99, 0, 0, 8'h80, 0, 0, 0, 8'h80);
    add("call90",  1, 0, 8'h00, 1, 8'h90, 0, 0, 8'h90, 1, 0, 0, 8'h90);

    // Reset state, before any clock edge.
    #2;
    check("rst.pc",  {24'd0, o_pc},      32'h0);
    check("rst.cnt", {29'd0, ras_count}, 32'h0);
    check("rst.ovf", {31'd0, ras_overflow},  32'h0);
    check("rst.unf", {31'd0, ras_underflow}, 32'h0);
    check("rst.pcplus", {24'd0, pc_plus}, 32'h1);

    // Sequential fetch across the full range, wrapping 0xFF -> 0x00.
    @(negedge clk);
    rst   = 1'b1;
    wpcir = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk);
      #1;
      check("seq.pc", {24'd0, o_pc}, i % 256);
    end
    check("wrap.ovf", {31'd0, ras_overflow}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Asynchronous reset mid-stream, away from any clock edge.
    #2;
    rst = 1'b0;
    #1;
    check("arst.pc",  {24'd0, o_pc},      32'h0);
    check("arst.cnt", {29'd0, ras_count}, 32'h0);
    check("arst.ovf", {31'd0, ras_overflow}, 32'h0);
    @(negedge clk);
    wpcir = 1'b1; redirect_valid = 1'b0; is_call = 1'b0; is_ret = 1'b0; clr_flags = 1'b0;
    @(posedge clk);
    #1;
    check("arst.hold", {24'd0, o_pc}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("release.pc", {24'd0, o_pc}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
